// File: rtl/booth_mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package booth_mult_pkg;

    localparam int WIDTH = 32;
    localparam int ACC_W = 33;
    localparam int CNT_W = 6;

    localparam logic [CNT_W-1:0] LAST_STEP = 6'd31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/booth_mult_seq_add_sub.sv
// 33-bit combinational adder/subtractor used once per Booth step.
module booth_add_sub
    import booth_mult_pkg::*;
(
    input  logic [ACC_W-1:0] a,
    input  logic [ACC_W-1:0] b,
    input  logic             sub,
    output logic [ACC_W-1:0] y
);

    logic [ACC_W-1:0] b_eff;

    assign b_eff = sub ? ~b : b;
    assign y     = a + b_eff + {{(ACC_W-1){1'b0}}, sub};

endmodule

// File: rtl/booth_mult_seq.sv
// Sequential 32x32 signed radix-2 Booth multiplier, one step per clock.
// Define BOOTH_MULT_OVF_EN to enable the signed-32 overflow exception.
module booth_mult_seq
    import booth_mult_pkg::*;
(
    input  logic             clock,
    input  logic             resetn,
    input  logic             start,
    input  logic [WIDTH-1:0] data_a,
    input  logic [WIDTH-1:0] data_b,
    output logic [WIDTH-1:0] result,
    output logic             exception,
    output logic             ready,
    output logic             busy
);

    state_t           state;
    logic [ACC_W-1:0] mcand;
    logic [ACC_W-1:0] acc;
    logic [WIDTH-1:0] q;
    logic             qm1;
    logic [CNT_W-1:0] cnt;

    logic             do_sub;
    logic             use_m;
    logic [ACC_W-1:0] addend;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_n;
    logic [WIDTH-1:0] q_n;
    logic             ovf_n;

    // Booth pair {q[0],qm1}: 01 adds, 10 subtracts, 00/11 pass
    assign do_sub = q[0] & ~qm1;
    assign use_m  = q[0] ^ qm1;
    assign addend = use_m ? mcand : '0;

    booth_add_sub u_add_sub (
        .a   (acc),
        .b   (addend),
        .sub (do_sub),
        .y   (sum)
    );

    assign acc_n = {sum[ACC_W-1], sum[ACC_W-1:1]};
    assign q_n   = {sum[0], q[WIDTH-1:1]};

`ifdef BOOTH_MULT_OVF_EN
    // high word of the product must be the sign extension of the low word
    assign ovf_n = acc_n[WIDTH-1:0] != {WIDTH{q_n[WIDTH-1]}};
`else
    assign ovf_n = 1'b0;
`endif

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            mcand     <= '0;
            acc       <= '0;
            q         <= '0;
            qm1       <= 1'b0;
            cnt       <= '0;
            result    <= '0;
            exception <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ready <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        mcand <= {data_a[WIDTH-1], data_a};
                        acc   <= '0;
                        q     <= data_b;
                        qm1   <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                RUN: begin
                    acc <= acc_n;
                    q   <= q_n;
                    qm1 <= q[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST_STEP) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        ready     <= 1'b1;
                        result    <= q_n;
                        exception <= ovf_n;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
